// File: rtl/fifo_fwft_if.sv
// Handshake bundle between a FIFO and its producer/consumer.
// The master modport drives push/pop requests; the slave modport is the FIFO side.
interface fifo_fwft_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int BUFFER_SIZE = 16
);
   localparam int ADDR_WIDTH = $clog2(BUFFER_SIZE);

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] din;
   logic                  full;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] dout;
   logic                  empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, din, rd_en,
      input  full, dout, empty, count, overflow, underflow
   );

   modport slave (
      input  wr_en, din, rd_en,
      output full, dout, empty, count, overflow, underflow
   );
endinterface

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO: the head word is visible on dout whenever empty=0,
// so a consumer samples dout in the same cycle it asserts rd_en.
module fifo_fwft #(
   parameter int FIFO_DATA_WIDTH  = 32,
   parameter int FIFO_BUFFER_SIZE = 16
) (
   input logic        clock_i,
   input logic        reset_n_i,
   fifo_fwft_if.slave bus
);
   localparam int ADDR_WIDTH = $clog2(FIFO_BUFFER_SIZE);
   localparam logic [ADDR_WIDTH:0] COUNT_FULL = (ADDR_WIDTH+1)'(FIFO_BUFFER_SIZE);

   logic [FIFO_DATA_WIDTH-1:0] mem_q [FIFO_BUFFER_SIZE];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q,  count_d;
   logic                  empty_q,  empty_d;
   logic                  full_q,   full_d;
   logic                  overflow_q,  overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  push, pop;

   // Requests are qualified by the registered flags, so no combinational
   // path exists from wr_en/rd_en back to full/empty/count.
   always_comb begin
      push        = bus.wr_en & ~full_q;
      pop         = bus.rd_en & ~empty_q;
      wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      overflow_d  = bus.wr_en & full_q;
      underflow_d = bus.rd_en & empty_q;
      count_d     = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      empty_d = (count_d == '0);
      full_d  = (count_d == COUNT_FULL);
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         empty_q     <= empty_d;
         full_q      <= full_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is not reset; stale contents are masked by empty_q on dout.
   always_ff @(posedge clock_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.din;
      end
   end

   assign bus.dout      = empty_q ? '0 : mem_q[rd_ptr_q];
   assign bus.empty     = empty_q;
   assign bus.full      = full_q;
   assign bus.count     = count_q;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_fifo_fwft.sv
// Directed and model-checked stimulus for the FWFT FIFO at depth 16, width 32.
module tb_fifo_fwft;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   fifo_fwft_if #(.DATA_WIDTH(32), .BUFFER_SIZE(16)) bus ();

   fifo_fwft #(.FIFO_DATA_WIDTH(32), .FIFO_BUFFER_SIZE(16)) dut (
      .clock_i  (clk),
      .reset_n_i(rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b want 1", bus.empty); end
      n_cmp++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", bus.count); end
      n_cmp++; if (bus.dout !== 32'h0) begin n_err++; $display("FAIL rst_dout: got %h want 0", bus.dout); end
      for (int i = 0; i < 5; i++) begin
         bus.wr_en = 1'b1; bus.din = 32'h100 + i;
         tick();
      end
      bus.wr_en = 1'b0;
      n_cmp++; if (bus.count !== 5'd5) begin n_err++; $display("FAIL pre_rst_count: got %0d want 5", bus.count); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL async_rst_empty: got %b want 1", bus.empty); end
      n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL async_rst_full: got %b want 0", bus.full); end
      n_cmp++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL async_rst_count: got %0d want 0", bus.count); end
      n_cmp++; if (bus.dout !== 32'h0) begin n_err++; $display("FAIL async_rst_dout: got %h want 0", bus.dout); end
      tick();
      rst_n = 1'b1;
      tick();
      n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL post_rst_empty: got %b want 1", bus.empty); end
      $display("test_reset done");
   endtask

   task automatic test_single();
      bus.wr_en = 1'b1; bus.din = 32'hA5A5A5A5;
      #1;
      n_cmp++; if (bus.dout !== 32'h0) begin n_err++; $display("FAIL no_bypass_dout: got %h want 0", bus.dout); end
      tick();
      bus.wr_en = 1'b0;
      n_cmp++; if (bus.empty !== 1'b0) begin n_err++; $display("FAIL single_empty: got %b want 0", bus.empty); end
      n_cmp++; if (bus.dout !== 32'hA5A5A5A5) begin n_err++; $display("FAIL single_dout: got %h want a5a5a5a5", bus.dout); end
      n_cmp++; if (bus.count !== 5'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", bus.count); end
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL single_pop_empty: got %b want 1", bus.empty); end
      n_cmp++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL single_pop_count: got %0d want 0", bus.count); end
      n_cmp++; if (bus.underflow !== 1'b0) begin n_err++; $display("FAIL single_pop_underflow: got %b want 0", bus.underflow); end
      $display("test_single done");
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 16; i++) begin
         bus.wr_en = 1'b1; bus.din = i;
         tick();
      end
      n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", bus.full); end
      n_cmp++; if (bus.count !== 5'd16) begin n_err++; $display("FAIL fill_count: got %0d want 16", bus.count); end
      n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL fill_no_overflow: got %b want 0", bus.overflow); end
      bus.din = 32'd99;
      tick();
      bus.wr_en = 1'b0;
      n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL overflow_pulse: got %b want 1", bus.overflow); end
      n_cmp++; if (bus.count !== 5'd16) begin n_err++; $display("FAIL overflow_count: got %0d want 16", bus.count); end
      tick();
      n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL overflow_clear: got %b want 0", bus.overflow); end
      bus.rd_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         n_cmp++; if (bus.dout !== 32'(i)) begin n_err++; $display("FAIL drain_dout[%0d]: got %h want %h", i, bus.dout, 32'(i)); end
         tick();
      end
      bus.rd_en = 1'b0;
      n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", bus.empty); end
      $display("test_fill_overflow done");
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 16; i++) begin
         bus.wr_en = 1'b1; bus.din = i;
         tick();
      end
      bus.rd_en = 1'b1; bus.din = 32'd77;
      tick();
      bus.wr_en = 1'b0; bus.rd_en = 1'b0;
      n_cmp++; if (bus.count !== 5'd15) begin n_err++; $display("FAIL full_both_count: got %0d want 15", bus.count); end
      n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL full_both_overflow: got %b want 1", bus.overflow); end
      n_cmp++; if (bus.dout !== 32'd1) begin n_err++; $display("FAIL full_both_dout: got %h want 1", bus.dout); end
      n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL full_both_full: got %b want 0", bus.full); end
      tick();
      n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL full_both_ovf_clear: got %b want 0", bus.overflow); end
      bus.rd_en = 1'b1;
      for (int i = 1; i < 16; i++) begin
         n_cmp++; if (bus.dout !== 32'(i)) begin n_err++; $display("FAIL full_both_drain[%0d]: got %h want %h", i, bus.dout, 32'(i)); end
         tick();
      end
      n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL full_both_empty: got %b want 1", bus.empty); end
      bus.wr_en = 1'b1; bus.din = 32'h55;
      tick();
      bus.wr_en = 1'b0; bus.rd_en = 1'b0;
      n_cmp++; if (bus.count !== 5'd1) begin n_err++; $display("FAIL empty_both_count: got %0d want 1", bus.count); end
      n_cmp++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL empty_both_underflow: got %b want 1", bus.underflow); end
      n_cmp++; if (bus.dout !== 32'h55) begin n_err++; $display("FAIL empty_both_dout: got %h want 55", bus.dout); end
      tick();
      n_cmp++; if (bus.underflow !== 1'b0) begin n_err++; $display("FAIL empty_both_unf_clear: got %b want 0", bus.underflow); end
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL empty_both_final: got %b want 1", bus.empty); end
      $display("test_simultaneous done");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         bus.wr_en = 1'b1; bus.din = 32'd1000 + i;
         tick();
      end
      bus.rd_en = 1'b1;
      for (int k = 0; k < 40; k++) begin
         bus.din = 32'd1008 + k;
         n_cmp++; if (bus.dout !== 32'd1000 + k) begin n_err++; $display("FAIL b2b_dout[%0d]: got %0d want %0d", k, bus.dout, 1000 + k); end
         tick();
         n_cmp++; if (bus.count !== 5'd8) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d want 8", k, bus.count); end
      end
      bus.wr_en = 1'b0;
      for (int k = 0; k < 8; k++) begin
         n_cmp++; if (bus.dout !== 32'd1040 + k) begin n_err++; $display("FAIL b2b_tail[%0d]: got %0d want %0d", k, bus.dout, 1040 + k); end
         tick();
      end
      bus.rd_en = 1'b0;
      n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty: got %b want 1", bus.empty); end
      $display("test_back_to_back done");
   endtask

   task automatic test_random();
      logic [31:0] q[$];
      logic        wr, rd, exp_ovf, exp_unf;
      logic [31:0] exp_dout;
      int          errs_before;
      errs_before = n_err;
      for (int c = 0; c < 10000; c++) begin
         wr = 1'($urandom_range(0, 1));
         rd = 1'($urandom_range(0, 1));
         bus.wr_en = wr; bus.rd_en = rd; bus.din = $urandom;
         exp_ovf = wr && (q.size() == 16);
         exp_unf = rd && (q.size() == 0);
         if (rd && q.size() > 0) void'(q.pop_front());
         if (wr && !exp_ovf) q.push_back(bus.din);
         tick();
         exp_dout = (q.size() > 0) ? q[0] : 32'h0;
         n_cmp++; if (bus.count !== 5'(q.size())) begin n_err++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, bus.count, q.size()); end
         n_cmp++; if (bus.empty !== (q.size() == 0)) begin n_err++; $display("FAIL rnd_empty@%0d: got %b want %b", c, bus.empty, q.size() == 0); end
         n_cmp++; if (bus.full !== (q.size() == 16)) begin n_err++; $display("FAIL rnd_full@%0d: got %b want %b", c, bus.full, q.size() == 16); end
         n_cmp++; if (bus.dout !== exp_dout) begin n_err++; $display("FAIL rnd_dout@%0d: got %h want %h", c, bus.dout, exp_dout); end
         n_cmp++; if (bus.overflow !== exp_ovf) begin n_err++; $display("FAIL rnd_overflow@%0d: got %b want %b", c, bus.overflow, exp_ovf); end
         n_cmp++; if (bus.underflow !== exp_unf) begin n_err++; $display("FAIL rnd_underflow@%0d: got %b want %b", c, bus.underflow, exp_unf); end
      end
      bus.wr_en = 1'b0; bus.rd_en = 1'b0;
      $display("test_random done: %0d new errors", n_err - errs_before);
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.din = '0;
      rst_n = 1'b0;
      #12 rst_n = 1'b1;
      tick();
      test_reset();
      test_single();
      test_fill_overflow();
      test_simultaneous();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
